regfile_sb: RTL and testbench

- General-purpose register file with one write port and two combinational read ports, plus a per-register pending-write scoreboard.
- The write port is the receiving end of the writeback interface (regfile_wr / regfile_addr_wr / regfile_data_wr) driven by the WB stage.
- Read ports and scoreboard outputs serve the decode stage for operand fetch and RAW hazard detection.
- x0 is hardwired to zero.

---
 rtl/regfile_sb.sv | 71 +++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports with write-through
// bypass, and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regfile_wr,
  input  logic [ADDR_W-1:0] regfile_addr_wr,
  input  logic [DATA_W-1:0] regfile_data_wr,
  input  logic [ADDR_W-1:0] addr_rs1,
  output logic [DATA_W-1:0] data_rs1,
  input  logic [ADDR_W-1:0] addr_rs2,
  output logic [DATA_W-1:0] data_rs2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              sb_flush,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_any
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic                w_hit1;
  logic                w_hit2;

  // A writeback landing this cycle both forwards its data and resolves the hazard.
  assign w_hit1 = regfile_wr && (regfile_addr_wr == addr_rs1);
  assign w_hit2 = regfile_wr && (regfile_addr_wr == addr_rs2);

  assign data_rs1 = (addr_rs1 == '0) ? '0 : (w_hit1 ? regfile_data_wr : r_regs[addr_rs1]);
  assign data_rs2 = (addr_rs2 == '0) ? '0 : (w_hit2 ? regfile_data_wr : r_regs[addr_rs2]);

  assign busy_rs1 = (addr_rs1 != '0) && r_pend[addr_rs1] && !w_hit1;
  assign busy_rs2 = (addr_rs2 != '0) && r_pend[addr_rs2] && !w_hit2;
  assign busy_any = |r_pend;

  // Set is applied last so a newly issued producer wins over a clear or a flush.
  always_comb begin
    w_pend_nxt = r_pend;
    if (sb_flush) begin
      w_pend_nxt = '0;
    end else if (regfile_wr) begin
      w_pend_nxt[regfile_addr_wr] = 1'b0;
    end
    if (sb_set && (sb_addr != '0)) begin
      w_pend_nxt[sb_addr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      if (regfile_wr && (regfile_addr_wr != '0)) begin
        r_regs[regfile_addr_wr] <= regfile_data_wr;
      end
      r_pend <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, flush/reset sequences, and random
// traffic compared against an array-based reference model.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        regfile_wr;
  logic [4:0]  regfile_addr_wr;
  logic [31:0] regfile_data_wr;
  logic [4:0]  addr_rs1;
  logic [31:0] data_rs1;
  logic [4:0]  addr_rs2;
  logic [31:0] data_rs2;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        sb_flush;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        busy_any;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        set;
    logic [4:0]  sa;
    logic        fl;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic        eany;
  } vec_t;

  vec_t tbl [17];

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .regfile_wr(regfile_wr), .regfile_addr_wr(regfile_addr_wr), .regfile_data_wr(regfile_data_wr),
    .addr_rs1(addr_rs1), .data_rs1(data_rs1),
    .addr_rs2(addr_rs2), .data_rs2(data_rs2),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_any(busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic set, input logic [4:0] sa, input logic fl);
    regfile_wr = wr; regfile_addr_wr = wa; regfile_data_wr = wd;
    addr_rs1 = a1; addr_rs2 = a2;
    sb_set = set; sb_addr = sa; sb_flush = fl;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (regfile_wr && regfile_addr_wr != 0) m_regs[regfile_addr_wr] = regfile_data_wr;
      if (sb_flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else if (regfile_wr) begin
        m_pend[regfile_addr_wr] = 1'b0;
      end
      if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [31:0] e_data(input logic [4:0] a);
    if (a == 0) return '0;
    if (regfile_wr && regfile_addr_wr == a) return regfile_data_wr;
    return m_regs[a];
  endfunction

  function automatic logic e_busy(input logic [4:0] a);
    return (a != 0) && m_pend[a] && !(regfile_wr && regfile_addr_wr == a);
  endfunction

  function automatic logic e_any();
    for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    tbl[0]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd31, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0,  1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd7,  1'b1, 5'd0,  1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd3,  1'b1, 5'd3,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5'd3, 32'h55,       5'd3, 5'd3,  1'b0, 5'd0,  1'b0, 32'h55,       32'h55,       1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd3,  1'b0, 5'd0,  1'b0, 32'h0,        32'h55,       1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd0,  1'b1, 5'd4,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 5'd4, 32'hA,        5'd4, 5'd0,  1'b1, 5'd4,  1'b0, 32'hA,        32'h0,        1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd0,  1'b0, 5'd0,  1'b0, 32'hA,        32'h0,        1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 5'd4, 32'hB,        5'd4, 5'd4,  1'b0, 5'd0,  1'b0, 32'hB,        32'hB,        1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd7,  1'b0, 5'd0,  1'b0, 32'hB,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 5'd5, 32'h77,       5'd5, 5'd6,  1'b1, 5'd6,  1'b0, 32'h77,       32'h0,        1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd6,  1'b0, 5'd0,  1'b0, 32'h77,       32'h0,        1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 5'd6, 32'h66,       5'd5, 5'd6,  1'b0, 5'd0,  1'b0, 32'h77,       32'h66,       1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 5'd0, 32'h0,        5'd6, 5'd0,  1'b0, 5'd0,  1'b0, 32'h66,       32'h0,        1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    drv(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0, 5'd0, 1'b0);
    model_clear();
    #2;
    chk("rst_data_rs1", data_rs1, 32'h0);
    chk("rst_data_rs2", data_rs2, 32'h0);
    chk("rst_busy_any", {31'b0, busy_any}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      drv(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2, tbl[i].set, tbl[i].sa, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_data_rs1", i), data_rs1, tbl[i].e1);
      chk($sformatf("vec%0d_data_rs2", i), data_rs2, tbl[i].e2);
      chk($sformatf("vec%0d_busy_rs1", i), {31'b0, busy_rs1}, {31'b0, tbl[i].eb1});
      chk($sformatf("vec%0d_busy_rs2", i), {31'b0, busy_rs2}, {31'b0, tbl[i].eb2});
      chk($sformatf("vec%0d_busy_any", i), {31'b0, busy_any}, {31'b0, tbl[i].eany});
      tick();
    end

    // Flush with a coincident set and a coincident write.
    drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0); tick();
    drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0); tick();
    drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0); tick();
    drv(1'b1, 5'd2, 32'h22, 5'd1, 5'd10, 1'b1, 5'd10, 1'b1);
    @(negedge clk);
    chk("flush_pre_busy_rs1", {31'b0, busy_rs1}, 32'h1);
    chk("flush_pre_busy_rs2", {31'b0, busy_rs2}, 32'h0);
    chk("flush_pre_busy_any", {31'b0, busy_any}, 32'h1);
    tick();
    drv(1'b0, 5'd0, 32'h0, 5'd1, 5'd10, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("flush_post_busy_x1",  {31'b0, busy_rs1}, 32'h0);
    chk("flush_post_busy_x10", {31'b0, busy_rs2}, 32'h1);
    chk("flush_post_busy_any", {31'b0, busy_any}, 32'h1);
    drv(1'b0, 5'd0, 32'h0, 5'd2, 5'd9, 1'b0, 5'd0, 1'b0);
    #1;
    chk("flush_write_x2",  data_rs1, 32'h22);
    chk("flush_busy_x2",   {31'b0, busy_rs1}, 32'h0);
    chk("flush_busy_x9",   {31'b0, busy_rs2}, 32'h0);
    tick();

    for (int n = 0; n < 400; n++) begin
      drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 15) == 0));
      @(negedge clk);
      chk($sformatf("rnd%0d_data_rs1", n), data_rs1, e_data(addr_rs1));
      chk($sformatf("rnd%0d_data_rs2", n), data_rs2, e_data(addr_rs2));
      chk($sformatf("rnd%0d_busy_rs1", n), {31'b0, busy_rs1}, {31'b0, e_busy(addr_rs1)});
      chk($sformatf("rnd%0d_busy_rs2", n), {31'b0, busy_rs2}, {31'b0, e_busy(addr_rs2)});
      chk($sformatf("rnd%0d_busy_any", n), {31'b0, busy_any}, {31'b0, e_any()});
      tick();
    end

    // Asynchronous reset mid-run, with a write held in flight across an edge.
    drv(1'b1, 5'd4, 32'h1234, 5'd4, 5'd4, 1'b1, 5'd4, 1'b0); tick();
    drv(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_data_x4", data_rs1, 32'h1234);
    chk("pre_rst_busy_any", {31'b0, busy_any}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data", data_rs1, 32'h0);
    chk("async_rst_busy_rs1", {31'b0, busy_rs1}, 32'h0);
    chk("async_rst_busy_any", {31'b0, busy_any}, 32'h0);
    drv(1'b1, 5'd4, 32'h99, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("post_rst_data_x4", data_rs1, 32'h0);
    chk("post_rst_busy_any", {31'b0, busy_any}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
